// File: rtl/lut_neuron_loader.sv
// Runtime-writable truth-table neuron: a load stream fills a shadow bank
// that is swapped in on commit; lookups read the active bank with one cycle of latency.
module lut_neuron_loader #(
  parameter int IN_BITS      = 6,
  parameter int OUT_BITS     = 2,
  parameter int WORD_ENTRIES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [OUT_BITS*WORD_ENTRIES-1:0] ld_data,
  input  logic                         ld_last,
  output logic                         ld_done,
  output logic                         ld_err,
  output logic                         bank_sel,
  input  logic [IN_BITS-1:0]           M0,
  input  logic                         in_valid,
  output logic [OUT_BITS-1:0]          M1,
  output logic                         out_valid
);

  localparam int DEPTH = 2 ** IN_BITS;
  localparam int BEATS = DEPTH / WORD_ENTRIES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LASTC = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] wr_slot;
  logic          wr_en;
  logic          err_d;
  logic          commit;
  logic          fire;

  logic [OUT_BITS-1:0] mem [2][DEPTH];

  assign ld_ready = (state_q != COMMIT);
  assign fire     = ld_valid & ld_ready;
  assign commit   = (state_q == COMMIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_slot = cnt_q;
    unique case (state_q)
      IDLE: begin
        wr_slot = '0;
        if (fire) begin
          wr_en = 1'b1;
          if (BEATS == 1) begin
            if (ld_last) state_d = COMMIT;
            else         err_d   = 1'b1;
          end else if (ld_last) begin
            err_d = 1'b1;
          end else begin
            cnt_d   = CW'(1);
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (fire) begin
          wr_en = 1'b1;
          if (cnt_q == LASTC) begin
            cnt_d = '0;
            if (ld_last) begin
              state_d = COMMIT;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end else if (ld_last) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      COMMIT: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bank_sel  <= 1'b0;
      ld_done   <= 1'b0;
      ld_err    <= 1'b0;
      M1        <= '0;
      out_valid <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < DEPTH; a++)
          mem[b][a] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_err    <= err_d;
      ld_done   <= commit;
      out_valid <= in_valid;
      if (commit) bank_sel <= ~bank_sel;
      // bank_sel here is the pre-toggle value, so a COMMIT-cycle lookup sees the old table
      if (in_valid) M1 <= mem[bank_sel][M0];
      if (wr_en)
        for (int i = 0; i < WORD_ENTRIES; i++)
          mem[~bank_sel][IN_BITS'(int'(wr_slot) * WORD_ENTRIES + i)]
            <= ld_data[i*OUT_BITS +: OUT_BITS];
    end
  end

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Directed self-checking bench for lut_neuron_loader:
// table-driven lookups plus hand-written load/commit/error/reset sequences.
module tb_lut_neuron_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_valid;
  logic       ld_ready;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_done;
  logic       ld_err;
  logic       bank_sel;
  logic [5:0] M0;
  logic       in_valid;
  logic [1:0] M1;
  logic       out_valid;

  lut_neuron_loader dut (
    .clk(clk),
    .rst(rst),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_data(ld_data),
    .ld_last(ld_last),
    .ld_done(ld_done),
    .ld_err(ld_err),
    .bank_sel(bank_sel),
    .M0(M0),
    .in_valid(in_valid),
    .M1(M1),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [1:0] img [64];

  typedef struct {
    logic [5:0] a;
    logic [1:0] e;
  } vec_t;

  vec_t vecs [4];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    ld_valid = 1'b0;
    ld_last = 1'b0;
    ld_data = '0;
    in_valid = 1'b0;
    M0 = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic lookup(input logic [5:0] a, input logic [1:0] e,
                        input string nm);
    M0 = a;
    in_valid = 1'b1;
    tick;
    chk({nm, "_ov"}, 32'(out_valid), 32'd1);
    chk(nm, 32'(M1), 32'(e));
    in_valid = 1'b0;
  endtask

  task automatic send(input int nbeats, input int last_at, input bit gaps);
    int g;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps && (b % 3 == 1)) begin
        ld_valid = 1'b0;
        tick;
        tick;
      end
      for (int i = 0; i < 4; i++) ld_data[i*2 +: 2] = img[b*4+i];
      ld_last = (b == last_at);
      ld_valid = 1'b1;
      g = 0;
      while (!ld_ready && g < 8) begin
        tick;
        g++;
      end
      chk("ld_ready_wait", 32'(ld_ready), 32'd1);
      tick;
    end
    ld_valid = 1'b0;
    ld_last = 1'b0;
  endtask

  task automatic commit_check(input logic exp_bank);
    chk("commit_ready_low", 32'(ld_ready), 32'd0);
    chk("commit_done_early", 32'(ld_done), 32'd0);
    tick;
    chk("ld_done", 32'(ld_done), 32'd1);
    chk("bank_sel_new", 32'(bank_sel), 32'(exp_bank));
    chk("ready_back", 32'(ld_ready), 32'd1);
    tick;
    chk("ld_done_pulse", 32'(ld_done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{a: 6'd17, e: 2'b01};
    vecs[1] = '{a: 6'd9,  e: 2'b11};
    vecs[2] = '{a: 6'd57, e: 2'b10};
    vecs[3] = '{a: 6'd0,  e: 2'b00};

    // Reset state and first lookup
    do_reset;
    chk("rst_ready", 32'(ld_ready), 32'd1);
    chk("rst_done", 32'(ld_done), 32'd0);
    chk("rst_err", 32'(ld_err), 32'd0);
    chk("rst_bank", 32'(bank_sel), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_m1", 32'(M1), 32'd0);
    lookup(6'd17, 2'b00, "t1_lookup17");

    // Full load with three set entries
    for (int i = 0; i < 64; i++) img[i] = 2'b00;
    img[17] = 2'b01;
    img[9]  = 2'b11;
    img[57] = 2'b10;
    send(16, 15, 1'b0);
    commit_check(1'b1);
    for (int k = 0; k < 4; k++)
      lookup(vecs[k].a, vecs[k].e, $sformatf("t2_vec%0d", k));
    lookup(6'd9, 2'b11, "t2_pre_hold");
    tick;
    chk("t2_ov_idle", 32'(out_valid), 32'd0);
    chk("t2_m1_hold", 32'(M1), 32'd3);

    // Back-to-back lookups across a commit: old all-00, new all-11
    do_reset;
    for (int i = 0; i < 64; i++) img[i] = 2'b11;
    in_valid = 1'b1;
    for (int b = 0; b < 16; b++) begin
      M0 = 6'(b * 4 + 1);
      for (int i = 0; i < 4; i++) ld_data[i*2 +: 2] = img[b*4+i];
      ld_last = (b == 15);
      ld_valid = 1'b1;
      tick;
      chk($sformatf("t3_ov_b%0d", b), 32'(out_valid), 32'd1);
      chk($sformatf("t3_old_b%0d", b), 32'(M1), 32'd0);
    end
    ld_valid = 1'b0;
    ld_last = 1'b0;
    chk("t3_commit_ready", 32'(ld_ready), 32'd0);
    M0 = 6'd42;
    tick;
    chk("t3_commit_lookup", 32'(M1), 32'd0);
    chk("t3_commit_ov", 32'(out_valid), 32'd1);
    chk("t3_done", 32'(ld_done), 32'd1);
    chk("t3_bank", 32'(bank_sel), 32'd1);
    tick;
    chk("t3_new_lookup", 32'(M1), 32'd3);
    chk("t3_new_ov", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick;

    // Early ld_last on the fifth beat
    for (int i = 0; i < 64; i++) img[i] = 2'(i);
    send(5, 4, 1'b0);
    chk("t4_err", 32'(ld_err), 32'd1);
    chk("t4_bank", 32'(bank_sel), 32'd1);
    tick;
    chk("t4_err_pulse", 32'(ld_err), 32'd0);
    lookup(6'd5, 2'b11, "t4_old_table");
    send(16, 15, 1'b0);
    commit_check(1'b0);
    lookup(6'd5, 2'b01, "t4_new5");
    lookup(6'd62, 2'b10, "t4_new62");

    // Sixteen beats without ld_last, then a gapped load
    for (int i = 0; i < 64; i++) img[i] = 2'((i >> 2) & 3);
    send(16, -1, 1'b0);
    chk("t5_err", 32'(ld_err), 32'd1);
    chk("t5_bank", 32'(bank_sel), 32'd0);
    tick;
    chk("t5_err_pulse", 32'(ld_err), 32'd0);
    chk("t5_done_none", 32'(ld_done), 32'd0);
    lookup(6'd6, 2'b10, "t5_old_table");
    send(16, 15, 1'b1);
    commit_check(1'b1);
    lookup(6'd6, 2'b01, "t5_new6");
    lookup(6'd63, 2'b11, "t5_new63");
    lookup(6'd40, 2'b10, "t5_new40");

    // Reset in the middle of a load
    for (int i = 0; i < 64; i++) img[i] = 2'b11;
    send(8, -1, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t6_bank", 32'(bank_sel), 32'd0);
    chk("t6_ready", 32'(ld_ready), 32'd1);
    chk("t6_err", 32'(ld_err), 32'd0);
    lookup(6'd40, 2'b00, "t6_rst40");
    lookup(6'd6, 2'b00, "t6_rst6");
    send(16, 15, 1'b0);
    chk("t6_no_err", 32'(ld_err), 32'd0);
    commit_check(1'b1);
    lookup(6'd40, 2'b11, "t6_new40");
    lookup(6'd0, 2'b11, "t6_new0");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
